// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an 8:1 mux select through the enabled channels in
// ascending order, waits SETTLE_CYCLES on each, samples the mux output and
// assembles the samples into one 8-bit word with a start/busy/done handshake.
// Optional build macro CONT_SCAN_EN: a start held high at the last sample edge
// chains the next scan with no idle cycle in between.
//
// state  | meaning
// IDLE   | waiting for start; s=0, busy=0
// SETTLE | holding s on a channel, sampling mux_o when the settle count expires
module mux_scan_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic       mux_o,
    output logic [2:0] s,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] sampled;
    logic [7:0] higher;

    // Lowest set bit of m; callers only use it when m is non-zero.
    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] ch;
        ch = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (m[k]) ch = 3'(k);
        end
        return ch;
    endfunction

    // Next-state logic for the scan FSM, settle counter and sample shadow.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sampled  = shadow_q;
        higher   = mask_q & (8'hFE << s_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d   = mask;
                    shadow_d = 8'h00;
                    if (mask == 8'h00) begin
                        data_d = 8'h00;
                        done_d = 1'b1;
                    end else begin
                        s_d     = lowest_ch(mask);
                        cnt_d   = CNT_RELOAD;
                        busy_d  = 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sampled[s_q] = mux_o;
                    shadow_d     = sampled;
                    if (higher != 8'h00) begin
                        s_d   = lowest_ch(higher);
                        cnt_d = CNT_RELOAD;
                    end else begin
                        // Shadow is cleared at acceptance, the mask AND just
                        // makes the zero-for-masked-channels rule explicit.
                        data_d  = sampled & mask_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        s_d     = 3'd0;
                        state_d = ST_IDLE;
`ifdef CONT_SCAN_EN
                        if (start) begin
                            mask_d   = mask;
                            shadow_d = 8'h00;
                            if (mask != 8'h00) begin
                                s_d     = lowest_ch(mask);
                                cnt_d   = CNT_RELOAD;
                                busy_d  = 1'b1;
                                state_d = ST_SETTLE;
                            end
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            s_q      <= 3'd0;
            cnt_q    <= 4'd0;
            mask_q   <= 8'h00;
            shadow_q <= 8'h00;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign s    = s_q;
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 1 and 3) share stimulus;
// a schedule-based model predicts s/busy/done/data every cycle. Build with
// CONT_SCAN_EN defined to exercise the chained-scan variant.
module tb_mux_scan_sequencer;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] mux_in = 8'h00;
    logic       mux_o0, mux_o1;
    logic [2:0] d_s    [2];
    logic       d_busy [2];
    logic       d_done [2];
    logic [7:0] d_data [2];

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    assign mux_o0 = mux_in[d_s[0]];
    assign mux_o1 = mux_in[d_s[1]];

    mux_scan_sequencer #(.SETTLE_CYCLES(S0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_o(mux_o0),
        .s(d_s[0]), .busy(d_busy[0]), .done(d_done[0]), .data(d_data[0])
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_o(mux_o1),
        .s(d_s[1]), .busy(d_busy[1]), .done(d_done[1]), .data(d_data[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A scan is a list of cycles, one entry per cycle the select is held;
    // the last entry of each channel is the one whose closing edge samples it.
    typedef struct packed {
        logic [2:0] ch;
        logic       smp;
    } step_t;

    step_t      sched [2][$];
    logic [2:0] m_s    [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic [7:0] m_data [2];
    logic [7:0] m_acc  [2];

    function automatic int sett(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    task automatic begin_scan(input int i, input logic [7:0] m);
        m_acc[i] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                for (int j = 0; j < sett(i); j++) begin
                    sched[i].push_back('{ch: 3'(k), smp: (j == sett(i) - 1)});
                end
            end
        end
        m_s[i]    = sched[i][0].ch;
        m_busy[i] = 1'b1;
    endtask

    always @(posedge clk) begin
        step_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                sched[i].delete();
                m_s[i] = 3'd0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
                m_data[i] = 8'h00; m_acc[i] = 8'h00;
            end else begin
                m_done[i] = 1'b0;
                if (sched[i].size() > 0) begin
                    e = sched[i].pop_front();
                    if (e.smp) m_acc[i][e.ch] = mux_in[e.ch];
                    if (sched[i].size() == 0) begin
                        m_data[i] = m_acc[i];
                        m_done[i] = 1'b1;
                        m_busy[i] = 1'b0;
                        m_s[i]    = 3'd0;
`ifdef CONT_SCAN_EN
                        if (start && mask != 8'h00) begin_scan(i, mask);
`endif
                    end else begin
                        m_s[i] = sched[i][0].ch;
                    end
                end else if (start) begin
                    if (mask == 8'h00) begin
                        m_data[i] = 8'h00;
                        m_done[i] = 1'b1;
                    end else begin
                        begin_scan(i, mask);
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("s%0d", i), 32'(d_s[i]), 32'(m_s[i]));
                chk($sformatf("busy%0d", i), 32'(d_busy[i]), 32'(m_busy[i]));
                chk($sformatf("done%0d", i), 32'(d_done[i]), 32'(m_done[i]));
                chk($sformatf("data%0d", i), 32'(d_data[i]), 32'(m_data[i]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    int         lat0, lat1;
    logic [7:0] dat0, dat1;
    logic [2:0] sq0[$];
    logic [2:0] sq1[$];

    // One start pulse, then record latency (edges after E0), data and the
    // select values seen while busy, for both instances.
    task automatic run_scan(input logic [7:0] m, input logic [7:0] in);
        @(negedge clk);
        mask = m; mux_in = in; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat0 = -1; lat1 = -1; dat0 = 8'hxx; dat1 = 8'hxx;
        sq0.delete(); sq1.delete();
        for (int c = 0; c < 200; c++) begin
            if (d_busy[0] && lat0 < 0) sq0.push_back(d_s[0]);
            if (d_busy[1] && lat1 < 0) sq1.push_back(d_s[1]);
            if (d_done[0] && lat0 < 0) begin lat0 = c; dat0 = d_data[0]; end
            if (d_done[1] && lat1 < 0) begin lat1 = c; dat1 = d_data[1]; end
            if (lat0 >= 0 && lat1 >= 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    // Edges until the next done of instance 0; -1 flags a timeout.
    task automatic wait_done0(output int waited);
        waited = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (d_done[0]) begin
                waited = c + 1;
                break;
            end
        end
        if (waited < 0) chk("done0_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int w, ndone;
        logic [2:0] exp_seq [9];

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, ndone;
        logic [2:0] exp_seq [9];

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_s", 32'(d_s[0]), 32'd0);
        chk("reset_busy", 32'(d_busy[0]), 32'd0);
        chk("reset_data", 32'(d_data[1]), 32'h00);
        repeat (2) @(negedge clk);

        // Full scan
        run_scan(8'hFF, 8'hA5);
        chk("full_lat0", 32'(lat0), 32'd8);
        chk("full_lat1", 32'(lat1), 32'd24);
        chk("full_data0", 32'(dat0), 32'hA5);
        chk("full_data1", 32'(dat1), 32'hA5);
        chk("full_sq0_len", 32'(sq0.size()), 32'd8);
        for (int k = 0; k < 8 && k < sq0.size(); k++) chk("full_sq0", 32'(sq0[k]), 32'(k));

        // Reset mid-scan
        @(negedge clk);
        mask = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_s0", 32'(d_s[0]), 32'd0);
        chk("rst_busy0", 32'(d_busy[0]), 32'd0);
        chk("rst_done0", 32'(d_done[0]), 32'd0);
        chk("rst_data0", 32'(d_data[0]), 32'h00);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (d_done[0] || d_done[1]) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);

        // Masked scan
        run_scan(8'b1001_0010, 8'hFF);
        chk("mask_lat1", 32'(lat1), 32'd9);
        chk("mask_lat0", 32'(lat0), 32'd3);
        chk("mask_data1", 32'(dat1), 32'h92);
        chk("mask_data0", 32'(dat0), 32'h92);
        exp_seq = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd4, 3'd7, 3'd7, 3'd7};
        chk("mask_sq1_len", 32'(sq1.size()), 32'd9);
        for (int k = 0; k < 9 && k < sq1.size(); k++) chk("mask_sq1", 32'(sq1[k]), 32'(exp_seq[k]));

        // Empty mask
        run_scan(8'h00, 8'hFF);
        chk("empty_lat0", 32'(lat0), 32'd0);
        chk("empty_lat1", 32'(lat1), 32'd0);
        chk("empty_data0", 32'(dat0), 32'h00);
        chk("empty_busy", 32'(sq0.size() + sq1.size()), 32'd0);

        // Start held high: back-to-back scans, mux input changed in between
        @(negedge clk);
        mask = 8'hFF; mux_in = 8'hA5; start = 1'b1;
        wait_done0(w);
        chk("b2b_data_first", 32'(d_data[0]), 32'hA5);
        mux_in = 8'h3C;
        wait_done0(w);
        chk("b2b_data_second", 32'(d_data[0]), 32'h3C);
`ifdef CONT_SCAN_EN
        chk("b2b_gap", 32'(w), 32'd8);
`else
        chk("b2b_gap", 32'(w), 32'd9);
`endif
        start = 1'b0;
        repeat (40) @(negedge clk);

`ifdef CONT_SCAN_EN
        // Continuous scanning
        @(negedge clk);
        mask = 8'h0F; mux_in = 8'h5A; start = 1'b1;
        wait_done0(w);
        for (int r = 0; r < 3; r++) begin
            chk("cont_busy_done", 32'(d_busy[0]), 32'd1);
            chk("cont_s_done", 32'(d_s[0]), 32'd0);
            for (int c = 1; c < 4; c++) begin
                @(negedge clk);
                chk("cont_s", 32'(d_s[0]), 32'(c));
                chk("cont_busy", 32'(d_busy[0]), 32'd1);
            end
            @(negedge clk);
            chk("cont_done", 32'(d_done[0]), 32'd1);
            chk("cont_data", 32'(d_data[0]), 32'h0A);
        end
        start = 1'b0;
        wait_done0(w);
        chk("cont_tail_gap", 32'(w), 32'd4);
        chk("cont_busy_fall", 32'(d_busy[0]), 32'd0);
        repeat (40) @(negedge clk);
`endif

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst    = ($urandom_range(0, 80) == 0);
            start  = ($urandom_range(0, 3) == 0);
            mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            mux_in = 8'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
